cfg_lut: RTL and testbench

CFG_LUT -- requirements
Module: cfg_lut

---
 rtl/cfg_lut_pkg.sv | 12 +
 rtl/cfg_lut_if.sv | 23 ++
 rtl/cfg_lut_loader.sv | 97 +++++++++
 rtl/cfg_lut.sv | 68 ++++++
 tb/tb_cfg_lut.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_lut_pkg.sv
// Shared definitions for the configurable LUT: loader state encoding and defaults.
package cfg_lut_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/cfg_lut_if.sv
// Lookup and serial-configuration signals of cfg_lut, bundled for port connection.
interface cfg_lut_if #(
   parameter int N = 2
);
   logic [N-1:0] in;
   logic         s;
   logic         cfg_start;
   logic         cfg_valid;
   logic         cfg_bit;
   logic         cfg_busy;
   logic         cfg_done;
   logic         cfg_err;

   modport master (
      output in, cfg_start, cfg_valid, cfg_bit,
      input  s, cfg_busy, cfg_done, cfg_err
   );

   modport slave (
      input  in, cfg_start, cfg_valid, cfg_bit,
      output s, cfg_busy, cfg_done, cfg_err
   );
endinterface

// File: rtl/cfg_lut_loader.sv
// Serial truth-table load sequencer: counts incoming bits, watches for idle timeout,
// and emits write / commit / abort strobes for the table storage in the top level.
module cfg_lut_loader
   import cfg_lut_pkg::*;
#(
   parameter int N       = 2,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cfg_start_i,
   input  logic         cfg_valid_i,
   output logic         wr_en_o,
   output logic [N-1:0] wr_idx_o,
   output logic         commit_o,
   output logic         abort_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam int         TW   = $clog2(TIMEOUT + 1);
   localparam logic [N:0] LAST = (N + 1)'((1 << N) - 1);

   state_e        state_q;
   logic [N:0]    cnt_q;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_d;
   logic          done_q;
   logic          err_q;
   logic          busy_q;

   // A start inside LOAD restarts the load, so it masks a coincident data bit.
   always_comb begin
      wr_en_o  = (state_q == LOAD) && !cfg_start_i && cfg_valid_i;
      wr_idx_o = cnt_q[N-1:0];
      abort_o  = (state_q == LOAD) && !cfg_start_i && !cfg_valid_i &&
                 ((int'(tmo_q) + 1) >= TIMEOUT);
      tmo_d    = (int'(tmo_q) >= TIMEOUT) ? tmo_q : tmo_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_start_i) begin
                  state_q <= LOAD;
                  cnt_q   <= '0;
                  tmo_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               if (cfg_start_i) begin
                  cnt_q <= '0;
                  tmo_q <= '0;
               end else if (cfg_valid_i) begin
                  cnt_q <= cnt_q + 1'b1;
                  tmo_q <= '0;
                  if (cnt_q == LAST) begin
                     state_q <= COMMIT;
                     done_q  <= 1'b1;
                  end
               end else begin
                  tmo_q <= tmo_d;
                  if (abort_o) begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            COMMIT: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign commit_o = done_q;
   assign busy_o   = busy_q;
   assign err_o    = err_q;

endmodule

// File: rtl/cfg_lut.sv
// Run-time reconfigurable N-input LUT with a registered output and a shadow table
// that is filled serially and swapped in atomically once a load completes.
module cfg_lut
   import cfg_lut_pkg::*;
#(
   parameter int              N       = 2,
   parameter logic [2**N-1:0] INIT    = {1'b1, {(2**N-1){1'b0}}},
   parameter int              TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic      clk,
   input logic      rst,
   cfg_lut_if.slave bus
);

   logic [2**N-1:0] active_q;
   logic [2**N-1:0] shadow_q;
   logic            s_q;

   logic            wr_en;
   logic [N-1:0]    wr_idx;
   logic            commit;
   logic            abort;
   logic            busy;
   logic            err;

   cfg_lut_loader #(
      .N       (N),
      .TIMEOUT (TIMEOUT)
   ) u_loader (
      .clk         (clk),
      .rst         (rst),
      .cfg_start_i (bus.cfg_start),
      .cfg_valid_i (bus.cfg_valid),
      .wr_en_o     (wr_en),
      .wr_idx_o    (wr_idx),
      .commit_o    (commit),
      .abort_o     (abort),
      .busy_o      (busy),
      .err_o       (err)
   );

   // The lookup reads the pre-commit table on the commit edge, so the new
   // table is first seen by the address presented in the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= INIT;
         shadow_q <= '0;
         s_q      <= 1'b0;
      end else begin
         s_q <= active_q[bus.in];
         if (wr_en) begin
            shadow_q[wr_idx] <= bus.cfg_bit;
         end
         if (abort) begin
            shadow_q <= '0;
         end
         if (commit) begin
            active_q <= shadow_q;
         end
      end
   end

   assign bus.s        = s_q;
   assign bus.cfg_busy = busy;
   assign bus.cfg_done = commit;
   assign bus.cfg_err  = err;

endmodule

// File: tb/tb_cfg_lut.sv
// Directed bench for cfg_lut at N=2 and N=4 with a per-cycle reference model.
module tb_cfg_lut;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] in_v    [2];
   logic       start_v [2];
   logic       valid_v [2];
   logic       bit_v   [2];
   logic       s_v     [2];
   logic       busy_v  [2];
   logic       done_v  [2];
   logic       err_v   [2];

   cfg_lut_if #(.N(2)) if2 ();
   cfg_lut_if #(.N(4)) if4 ();

   assign if2.in        = in_v[0][1:0];
   assign if2.cfg_start = start_v[0];
   assign if2.cfg_valid = valid_v[0];
   assign if2.cfg_bit   = bit_v[0];
   assign s_v[0]        = if2.s;
   assign busy_v[0]     = if2.cfg_busy;
   assign done_v[0]     = if2.cfg_done;
   assign err_v[0]      = if2.cfg_err;

   assign if4.in        = in_v[1];
   assign if4.cfg_start = start_v[1];
   assign if4.cfg_valid = valid_v[1];
   assign if4.cfg_bit   = bit_v[1];
   assign s_v[1]        = if4.s;
   assign busy_v[1]     = if4.cfg_busy;
   assign done_v[1]     = if4.cfg_done;
   assign err_v[1]      = if4.cfg_err;

   cfg_lut #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   cfg_lut #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model: a table, a list of bits received so far and an idle count.
   int          tsize [2] = '{4, 16};
   logic [15:0] tbl   [2];
   logic [15:0] shadow[2];
   bit          loading[2];
   int          nbits [2];
   int          idle  [2];
   logic        exp_s [2];
   logic        exp_busy[2];
   logic        exp_done[2];
   logic        exp_err [2];
   bit          model_ok = 1'b0;
   int          done_cnt[2] = '{0, 0};
   int          err_cnt [2] = '{0, 0};

   initial forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         bit was_done;
         if (rst) begin
            tbl[k]      = 16'(1) << (tsize[k] - 1);
            shadow[k]   = '0;
            loading[k]  = 1'b0;
            nbits[k]    = 0;
            idle[k]     = 0;
            exp_s[k]    = 1'b0;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
            exp_err[k]  = 1'b0;
            model_ok    = 1'b1;
         end else begin
            was_done    = exp_done[k];
            exp_done[k] = 1'b0;
            exp_err[k]  = 1'b0;
            exp_s[k]    = tbl[k][int'(in_v[k]) % tsize[k]];
            if (was_done) begin
               tbl[k]      = shadow[k];
               exp_busy[k] = 1'b0;
            end else if (loading[k]) begin
               if (start_v[k]) begin
                  nbits[k] = 0;
                  idle[k]  = 0;
               end else if (valid_v[k]) begin
                  shadow[k][nbits[k]] = bit_v[k];
                  nbits[k]++;
                  idle[k] = 0;
                  if (nbits[k] == tsize[k]) begin
                     loading[k]  = 1'b0;
                     exp_done[k] = 1'b1;
                  end
               end else begin
                  idle[k]++;
                  if (idle[k] == TMO) begin
                     loading[k]  = 1'b0;
                     exp_err[k]  = 1'b1;
                     exp_busy[k] = 1'b0;
                  end
               end
            end else if (start_v[k]) begin
               loading[k]  = 1'b1;
               nbits[k]    = 0;
               idle[k]     = 0;
               exp_busy[k] = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("n%0d_s", k), 32'(s_v[k]), 32'(exp_s[k]));
            chk($sformatf("n%0d_busy", k), 32'(busy_v[k]), 32'(exp_busy[k]));
            chk($sformatf("n%0d_done", k), 32'(done_v[k]), 32'(exp_done[k]));
            chk($sformatf("n%0d_err", k), 32'(err_v[k]), 32'(exp_err[k]));
            if (done_v[k] === 1'b1) done_cnt[k]++;
            if (err_v[k] === 1'b1)  err_cnt[k]++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sweep(input int k, input logic [15:0] exp_tbl, input string name);
      for (int i = 0; i < tsize[k]; i++) begin
         in_v[k] = 4'(i);
         cyc(1);
         $display("sweep %s n%0d in=%0d s=%0b", name, k, i, s_v[k]);
         chk($sformatf("%s_in%0d", name, i), 32'(s_v[k]), 32'(exp_tbl[i]));
      end
   endtask

   task automatic load(input int k, input logic [15:0] v, input int nb,
                       input bit gap, input bit collide);
      start_v[k] = 1'b1;
      valid_v[k] = collide;
      bit_v[k]   = 1'b1;
      cyc(1);
      start_v[k] = 1'b0;
      for (int b = 0; b < nb; b++) begin
         valid_v[k] = 1'b1;
         bit_v[k]   = v[b];
         in_v[k]    = 4'(b % tsize[k]);
         cyc(1);
         valid_v[k] = 1'b0;
         $display("load n%0d bit%0d=%0b busy=%0b done=%0b", k, b, v[b], busy_v[k], done_v[k]);
         chk($sformatf("busy_bit%0d", b), 32'(busy_v[k]), 32'd1);
         if (gap && b < nb - 1) begin
            cyc(1);
            chk($sformatf("busy_gap%0d", b), 32'(busy_v[k]), 32'd1);
         end
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
   endtask

   initial begin
      int d0, e0;
      for (int k = 0; k < 2; k++) begin
         in_v[k] = '0; start_v[k] = 1'b0; valid_v[k] = 1'b0; bit_v[k] = 1'b0;
      end
      cyc(2);
      rst = 1'b0;

      // AND after reset
      sweep(0, 16'h0008, "and2_rst");
      sweep(1, 16'h8000, "and4_rst");

      // timeout after two bits
      d0 = done_cnt[0]; e0 = err_cnt[0];
      load(0, 16'h0003, 2, 1'b0, 1'b0);
      cyc(15);
      chk("tmo_err_early", 32'(err_v[0]), 32'd0);
      chk("tmo_busy_early", 32'(busy_v[0]), 32'd1);
      cyc(1);
      $display("timeout err=%0b busy=%0b", err_v[0], busy_v[0]);
      chk("tmo_err", 32'(err_v[0]), 32'd1);
      chk("tmo_busy", 32'(busy_v[0]), 32'd0);
      cyc(1);
      chk("tmo_err_cnt", 32'(err_cnt[0] - e0), 32'd1);
      chk("tmo_done_cnt", 32'(done_cnt[0] - d0), 32'd0);
      sweep(0, 16'h0008, "and2_tmo");

      // reset in the middle of an OR load
      d0 = done_cnt[0]; e0 = err_cnt[0];
      load(0, 16'h000E, 3, 1'b0, 1'b0);
      pulse_rst();
      chk("rst_busy", 32'(busy_v[0]), 32'd0);
      cyc(1);
      chk("rst_pulses", 32'((done_cnt[0] - d0) + (err_cnt[0] - e0)), 32'd0);
      sweep(0, 16'h0008, "and2_rstmid");

      // XOR load, start coinciding with a valid bit that must be ignored
      d0 = done_cnt[0];
      load(0, 16'h0006, 4, 1'b0, 1'b1);
      chk("xor_done", 32'(done_v[0]), 32'd1);
      cyc(1);
      chk("xor_busy_after", 32'(busy_v[0]), 32'd0);
      chk("xor_done_cnt", 32'(done_cnt[0] - d0), 32'd1);
      sweep(0, 16'h0006, "xor2");

      // same XOR load with gaps, from the reset table
      pulse_rst();
      d0 = done_cnt[0];
      load(0, 16'h0006, 4, 1'b1, 1'b0);
      chk("gxor_done", 32'(done_v[0]), 32'd1);
      cyc(1);
      chk("gxor_done_cnt", 32'(done_cnt[0] - d0), 32'd1);
      sweep(0, 16'h0006, "gxor2");

      // N=4: OR4 load
      load(1, 16'hFFFE, 16, 1'b0, 1'b0);
      chk("or4_done", 32'(done_v[1]), 32'd1);
      cyc(1);
      sweep(1, 16'hFFFE, "or4");

      // N=4: restart after seven bits, then a full parity table
      d0 = done_cnt[1]; e0 = err_cnt[1];
      load(1, 16'h007F, 7, 1'b0, 1'b0);
      load(1, 16'h6996, 16, 1'b0, 1'b1);
      chk("par4_done", 32'(done_v[1]), 32'd1);
      cyc(1);
      chk("par4_done_cnt", 32'(done_cnt[1] - d0), 32'd1);
      chk("par4_err_cnt", 32'(err_cnt[1] - e0), 32'd0);
      sweep(1, 16'h6996, "par4");

      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
